// File: rtl/dpram_fifo_ctrl_pkg.sv
// dpram_pkg: shared defaults and word/address/level types for the
// dual-port-RAM FIFO controller and its output skid buffer.
package dpram_pkg;

  localparam int unsigned DW_DEFAULT = 8;
  localparam int unsigned AW_DEFAULT = 6;
  localparam int unsigned DEPTH      = 1 << AW_DEFAULT;

  typedef logic [AW_DEFAULT-1:0] addr_t;
  typedef logic [DW_DEFAULT-1:0] data_t;
  typedef logic [AW_DEFAULT:0]   lvl_t;

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// dpram_fifo_ctrl_if: producer (s_*) and consumer (m_*) valid/ready streams
// of the FIFO controller.
//   master : environment side (drives s_valid/s_data/m_ready)
//   slave  : controller side  (drives s_ready/m_valid/m_data)
interface dpram_fifo_ctrl_if
  import dpram_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) ();

  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

endinterface

// File: rtl/dpram_fifo_ctrl_out_skid.sv
// dpram_out_skid: 2-entry output buffer that absorbs the RAM's registered
// read latency. Entry e0 is always the head.
//   clk, rst_n  clock, async active-low reset
//   clr         synchronous clear
//   in_valid    write in_data into the tail this cycle
//   out_valid   head valid (cnt != 0)
//   out_ready   consumer takes the head
//   out_data    head word
//   cnt         entries held (0..2)
// The issuing logic upstream guarantees no write arrives while full
// without a simultaneous pop.
module dpram_out_skid
  import dpram_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    cnt
);

  logic [DW-1:0] e0, e1;
  logic [1:0]    cnt_q;
  logic          pop;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = e0;
  assign cnt       = cnt_q;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0    <= '0;
      e1    <= '0;
      cnt_q <= 2'd0;
    end else if (clr) begin
      cnt_q <= 2'd0;
    end else begin
      case ({in_valid, pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0 <= in_data;
          else               e1 <= in_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous pop and write: the new word lands behind whatever
          // remains after the head leaves.
          if (cnt_q == 2'd1) begin
            e0 <= in_data;
          end else begin
            e0 <= e1;
            e1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: sequences an external 2**AW x DW dual-port RAM as a FIFO.
// Port A writes (wr_ptr), port B reads (rd_ptr) with 1-cycle registered data;
// a 2-entry skid keeps throughput at one word per clock.
//   clk, rst_n        clock, async active-low reset
//   flush             synchronous clear of all FIFO state
//   bus (slave)       s_valid/s_ready/s_data in, m_valid/m_ready/m_data out
//   level             words held: RAM + in-flight read + skid
//   ram_*_a           write port (we = accepted push, addr = wr_ptr)
//   ram_*_b           read port (addr = rd_ptr, never written)
//   ram_q_b           registered read data from port B
module dpram_fifo_ctrl
  import dpram_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  dpram_fifo_ctrl_if.slave bus,
  output logic [AW:0]      level,
  output logic             ram_we_a,
  output logic [AW-1:0]    ram_addr_a,
  output logic [DW-1:0]    ram_data_a,
  output logic             ram_we_b,
  output logic [AW-1:0]    ram_addr_b,
  output logic [DW-1:0]    ram_data_b,
  input  logic [DW-1:0]    ram_q_b
);

  localparam int unsigned FIFO_DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT  = (AW+1)'(FIFO_DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   mem_cnt;
  logic          inflight;
  logic [1:0]    skid_cnt;
  logic          s_ready_i, m_valid_i;
  logic          push, pop, issue;
  logic [2:0]    skid_demand;

  // rst_n gates s_ready so no write strobe can escape while reset is held.
  assign s_ready_i = rst_n && (mem_cnt != DEPTH_CNT) && !flush;
  assign push      = bus.s_valid & s_ready_i;
  assign pop       = m_valid_i & bus.m_ready;

  // Skid slots committed after this edge; a pop implies skid_cnt >= 1.
  assign skid_demand = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue       = (mem_cnt != '0) && (skid_demand < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + (AW)'(1);
      if (issue) rd_ptr <= rd_ptr + (AW)'(1);
      inflight <= issue;
      case ({push, issue})
        2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  dpram_out_skid #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .in_valid  (inflight),
    .in_data   (ram_q_b),
    .out_valid (m_valid_i),
    .out_ready (bus.m_ready),
    .out_data  (bus.m_data),
    .cnt       (skid_cnt)
  );

  assign bus.s_ready = s_ready_i;
  assign bus.m_valid = m_valid_i;

  assign level = mem_cnt + (AW+1)'(inflight) + (AW+1)'(skid_cnt);

  assign ram_we_a   = push;
  assign ram_addr_a = wr_ptr;
  assign ram_data_a = bus.s_data;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rd_ptr;
  assign ram_data_b = '0;

endmodule
